// File: rtl/rotary_dial_encoder_pkg.sv
// Shared types and helpers for the vault dial front end: quadrature state
// encoding, position width and the transition classifier.
package dial_pkg;

    localparam int CODE_W = 5;

    // Enumerated in up-rotation order, so a legal up move is +1 modulo 4.
    typedef enum logic [1:0] {
        Q00 = 2'd0,
        Q10 = 2'd1,
        Q11 = 2'd2,
        Q01 = 2'd3
    } quad_state_t;

    typedef struct packed {
        logic [1:0] delta;   // two's complement: 01 = +1, 11 = -1, 00 = none
        logic       illegal;
    } quad_step_t;

    function automatic quad_state_t ab_to_state(input logic a, input logic b);
        quad_state_t s;
        case ({a, b})
            2'b00:   s = Q00;
            2'b10:   s = Q10;
            2'b11:   s = Q11;
            default: s = Q01;
        endcase
        return s;
    endfunction

    function automatic quad_step_t quad_delta(input quad_state_t prev, input quad_state_t next);
        quad_step_t r;
        logic [1:0] p;
        logic [1:0] n;
        logic [1:0] diff;
        p = prev;
        n = next;
        diff = n - p;
        r.delta = 2'b00;
        r.illegal = 1'b0;
        case (diff)
            2'd1:    r.delta = 2'b01;
            2'd3:    r.delta = 2'b11;
            2'd2:    r.illegal = 1'b1;
            default: r.delta = 2'b00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rotary_dial_encoder_if.sv
// Signal bundle between the dial front end and its consumer. The `clear`
// input exists only when DIAL_CLEAR_EN is defined.
interface rotary_dial_encoder_if;
    import dial_pkg::*;

    // Raw encoder phases have no handshake: they are level inputs sampled
    // every clock; step/quad_err are single-cycle strobes with no ready.
    logic              rot_a;
    logic              rot_b;
    logic [CODE_W-1:0] vault_code;
    logic              direction;
    logic              step;
    logic              quad_err;
    quad_state_t       quad_dbg;
`ifdef DIAL_CLEAR_EN
    logic              clear;

    modport master (
        output rot_a, rot_b, clear,
        input  vault_code, direction, step, quad_err, quad_dbg
    );
    modport slave (
        input  rot_a, rot_b, clear,
        output vault_code, direction, step, quad_err, quad_dbg
    );
`else
    modport master (
        output rot_a, rot_b,
        input  vault_code, direction, step, quad_err, quad_dbg
    );
    modport slave (
        input  rot_a, rot_b,
        output vault_code, direction, step, quad_err, quad_dbg
    );
`endif

endinterface

// File: rtl/rotary_dial_encoder_input_debouncer.sv
// Two-flop synchroniser followed by a stability counter; the output only
// follows the synced input after DEBOUNCE_CYCLES consecutive differing cycles.
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clock,
    input  logic n_reset,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = din;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            cnt_d = cnt_q + CW'(1);
            // Clearing on acceptance keeps the counter in range if the
            // input flips again right away.
            if (cnt_d == CW'(DEBOUNCE_CYCLES)) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout = stable_q;

endmodule

// File: rtl/rotary_dial_encoder.sv
// Vault dial front end: debounced quadrature decode into a wrapping position.
// Optional synchronous position clear is enabled with DIAL_CLEAR_EN.
module rotary_dial_encoder
    import dial_pkg::*;
#(
    parameter int CODE_MAX        = 31,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input logic                  clock,
    input logic                  n_reset,
    rotary_dial_encoder_if.slave bus
);

    logic              stable_a, stable_b;
    quad_state_t       quad_q, quad_d;
    quad_step_t        qs;
    logic [2:0]        substep_q, substep_d;
    logic [3:0]        sub_sum;
    logic [CODE_W-1:0] vault_code_q, vault_code_d;
    logic              direction_q, direction_d;
    logic              step_q, step_d;
    logic              quad_err_q, quad_err_d;

    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clock   (clock),
        .n_reset (n_reset),
        .din     (bus.rot_a),
        .dout    (stable_a)
    );

    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clock   (clock),
        .n_reset (n_reset),
        .din     (bus.rot_b),
        .dout    (stable_b)
    );

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            quad_q       <= Q00;
            substep_q    <= '0;
            vault_code_q <= '0;
            direction_q  <= 1'b0;
            step_q       <= 1'b0;
            quad_err_q   <= 1'b0;
        end else begin
            quad_q       <= quad_d;
            substep_q    <= substep_d;
            vault_code_q <= vault_code_d;
            direction_q  <= direction_d;
            step_q       <= step_d;
            quad_err_q   <= quad_err_d;
        end
    end

    // The FSM always adopts the debounced phase pair, even after an illegal jump.
    always_comb begin
        quad_d = ab_to_state(stable_a, stable_b);
    end

    always_comb begin
        qs           = quad_delta(quad_q, quad_d);
        sub_sum      = {substep_q[2], substep_q} + {{2{qs.delta[1]}}, qs.delta};
        substep_d    = substep_q;
        vault_code_d = vault_code_q;
        direction_d  = direction_q;
        step_d       = 1'b0;
        quad_err_d   = 1'b0;
        if (qs.illegal) begin
            quad_err_d = 1'b1;
            substep_d  = '0;
        end else if (quad_d != quad_q) begin
            if (quad_d == Q00) begin
                substep_d = '0;
                if (sub_sum == 4'b0100) begin
                    step_d       = 1'b1;
                    direction_d  = 1'b1;
                    vault_code_d = (vault_code_q == CODE_W'(CODE_MAX)) ? '0
                                                                       : vault_code_q + CODE_W'(1);
                end else if (sub_sum == 4'b1100) begin
                    step_d       = 1'b1;
                    direction_d  = 1'b0;
                    vault_code_d = (vault_code_q == '0) ? CODE_W'(CODE_MAX)
                                                        : vault_code_q - CODE_W'(1);
                end
            end else begin
                substep_d = sub_sum[2:0];
            end
        end
`ifdef DIAL_CLEAR_EN
        // Clear overrides a coincident step; sub-step reset above still applies.
        if (bus.clear) begin
            vault_code_d = '0;
            direction_d  = direction_q;
            step_d       = 1'b0;
        end
`endif
    end

    assign bus.vault_code = vault_code_q;
    assign bus.direction  = direction_q;
    assign bus.step       = step_q;
    assign bus.quad_err   = quad_err_q;
    assign bus.quad_dbg   = quad_q;

endmodule

// File: doc/rotary_dial_encoder.md
Name: rotary_dial_encoder

Overview:
Front end for the vault dial. Takes raw two-phase (quadrature) signals from the rotary encoder, synchronises and debounces them, and decodes full detent steps. Produces the 5-bit dial position `vault_code` and the turning `direction` consumed by the vault controller. It also provides a one-cycle step strobe and an error strobe for LEDs and debug.

Parameters:
- CODE_MAX, 31: highest dial value; legal range 1..31; position wraps between 0 and CODE_MAX.
- DEBOUNCE_CYCLES, 1000: consecutive stable clock cycles required before a synced input change is accepted; minimum 1.

Ports:
- clock  in  1  system clock
- n_reset  in  1  asynchronous, active-low reset
- rot_a  in  1  raw encoder phase A, asynchronous to clock
- rot_b  in  1  raw encoder phase B, asynchronous to clock
- vault_code  out  5  current dial position, 0..CODE_MAX
- direction  out  1  last step direction; 1 = up (clockwise), 0 = down
- step  out  1  one-cycle pulse on every accepted detent step
- quad_err  out  1  one-cycle pulse on an illegal quadrature transition

Behaviour:
- Reset is decided: n_reset is asynchronous and active-low; clock is `clock`.
- Reset values:
  - vault_code = 0, direction = 0, step = 0, quad_err = 0.
  - Debounced A/B = 0/0 (detent position), synchroniser flops = 0.
  - Sub-step counter = 0, FSM in Q00.
- Synchronisation: each of rot_a/rot_b passes through 2 flip-flops.
- Debounce, per input:
  - A counter runs while the synced value differs from the stable value.
  - The stable value updates on the cycle the counter reaches DEBOUNCE_CYCLES.
  - The counter clears whenever the synced value equals the stable value.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- Quadrature FSM:
  - States Q00, Q10, Q11, Q01, named by stable (A,B).
  - Up sequence: Q00→Q10→Q11→Q01→Q00.
  - Down sequence: the reverse of the up sequence.
- Sub-step counter (signed 3-bit): +1 per up transition, −1 per down transition, evaluated on the stable-value change cycle.
- Step acceptance:
  - On entering Q00 with sub-step = +4 (including that transition): step=1, direction=1, and vault_code increments, CODE_MAX→0.
  - With −4: step=1, direction=0, and vault_code decrements, 0→CODE_MAX.
  - Sub-step then clears to 0.
- Partial rotation: entering Q00 with any other count (partial turn, reversal mid-detent) clears sub-step with no step and no code change.
- Illegal transition (both stable bits change in the same cycle):
  - quad_err pulses for 1 cycle.
  - FSM adopts the new state; sub-step clears.
  - vault_code and direction are unchanged.
- Latency:
  - Raw edge to stable update: 2 + DEBOUNCE_CYCLES cycles.
  - Final stable transition into Q00 to updated vault_code/direction/step: 1 cycle, all registered outputs.
- Hold behaviour:
  - direction holds its last value while idle.
  - vault_code never leaves 0..CODE_MAX.
  - step and quad_err are never high in the same cycle.
- Reset mid-rotation aborts any partial step; decoding restarts from Q00 with sub-step 0. If the dial is physically off-detent, the next return to Q00 produces no step.

Optional Feature:
Macro DIAL_CLEAR_EN.
- Defined:
  - Adds input port `clear` (1 bit, synchronous, active-high, already debounced by its source).
  - When high, vault_code ← 0 on the next edge; direction is unchanged; no step pulse.
  - If a step qualifies in the same cycle, clear wins, but sub-step still resets.
- Undefined: there is no `clear` port and the position only changes by rotation.

Decomposition:
- Package `dial_pkg`:
  - `quad_state_t` enum {Q00, Q10, Q11, Q01}.
  - Localparam CODE_W = 5.
  - Function `quad_delta(prev, next)` returning −1, 0 or +1, plus an illegal flag.
- Sub-module `input_debouncer` (parameter DEBOUNCE_CYCLES; ports clock, n_reset, din, dout) containing the 2-flop synchroniser and the counter. It is instantiated twice, once per phase.

Test Plan:
All scenarios use DEBOUNCE_CYCLES = 4 and CODE_MAX = 31.
- Release reset, inputs idle at 0/0 → vault_code=0, direction=0, step never asserts for 100 cycles.
- Drive one full up sequence, each phase held 10 cycles → exactly one step pulse, vault_code=1, direction=1; repeat 6 more times → vault_code=7.
- From vault_code=0, drive one down detent → vault_code=31, direction=0; then one up detent → vault_code=0, direction=1.
- Glitch rot_a high for 3 cycles (< debounce) → no state change, no step, no quad_err.
- Go 00→10→11 then back 11→10→00 (reversal) → no step, vault_code unchanged; then jump stable 00→11 → quad_err one cycle, code unchanged.
- Assert n_reset mid-detent at Q11 → all outputs 0 immediately; complete the rotation → no step. With DIAL_CLEAR_EN, at vault_code=22 pulse clear coincident with a step → vault_code=0.
